// File: rtl/mem_bank_pkg.sv
// rtl/mem_bank_pkg.sv - shared constants and helpers for the single-bank SRAM model
package mem_bank_pkg;

  // Atomic-operation code meaning "plain access"; anything else is unsupported.
  localparam logic [5:0] ATOP_NONE = 6'h00;

  // Number of low address bits that select a byte within one bank word.
  function automatic int unsigned byte_off_w(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic logic is_atop_none(input logic [5:0] atop);
    return atop == ATOP_NONE;
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// rtl/mem_rsp_pipe.sv - fixed-depth valid/data response shift register
module mem_rsp_pipe #(
  parameter int unsigned Latency   = 1,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  output logic [DataWidth-1:0] out_data_o
);

  logic [Latency-1:0]   valid_q, valid_d;
  logic [DataWidth-1:0] data_q [Latency];
  logic [DataWidth-1:0] data_d [Latency];

  // Shift valids every cycle; data only moves with a valid so the output word holds between responses.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    valid_d[0] = in_valid_i;
    if (in_valid_i) data_d[0] = in_data_i;
    for (int s = 1; s < Latency; s++) begin
      valid_d[s] = valid_q[s-1];
      if (valid_q[s-1]) data_d[s] = data_q[s-1];
    end
  end

  // Pipeline registers; reset drops every in-flight response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int s = 0; s < Latency; s++) data_q[s] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q[Latency-1];
  assign out_data_o  = data_q[Latency-1];

endmodule

// File: rtl/mem_sram_bank.sv
// rtl/mem_sram_bank.sv - single-bank SRAM with combinational grant and fixed read latency
module mem_sram_bank
  import mem_bank_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned Latency   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_strb_i,
  input  logic [5:0]             mem_atop_i,
  input  logic                   mem_we_i,
  output logic                   mem_rvalid_o,
  output logic [DataWidth-1:0]   mem_rdata_o,
  output logic                   atop_err_o
);

  localparam int unsigned OffW  = byte_off_w(DataWidth);
  localparam int unsigned IdxW  = $clog2(NumWords);
  localparam int unsigned StrbW = DataWidth / 8;

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [IdxW-1:0]      idx;
  logic                 gnt;
  logic [DataWidth-1:0] rd_word;
  logic                 atop_err_q, atop_err_d;
  logic                 unused_addr;

  assign gnt       = mem_req_i & ~stall_i & ~rst_i;
  assign mem_gnt_o = gnt;
  // Upper bits wrap and byte-offset bits are don't-care.
  assign idx         = mem_addr_i[IdxW+OffW-1:OffW];
  assign unused_addr = ^mem_addr_i;
  // Read-before-write: the response carries the word as it was before this edge's write.
  assign rd_word = mem_q[idx];

  // Byte-masked write into storage; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (gnt && mem_we_i) begin
      for (int b = 0; b < StrbW; b++) begin
        if (mem_strb_i[b]) mem_q[idx][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
      end
    end
  end

  // Sticky flag for granted requests carrying an unsupported atomic code.
  always_comb begin
    atop_err_d = atop_err_q;
    if (gnt && !is_atop_none(mem_atop_i)) atop_err_d = 1'b1;
  end

  // Flag register, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) atop_err_q <= 1'b0;
    else       atop_err_q <= atop_err_d;
  end

  assign atop_err_o = atop_err_q;

  mem_rsp_pipe #(
    .Latency  (Latency),
    .DataWidth(DataWidth)
  ) u_rsp_pipe (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (gnt),
    .in_data_i  (rd_word),
    .out_valid_o(mem_rvalid_o),
    .out_data_o (mem_rdata_o)
  );

endmodule

// File: tb/tb_mem_sram_bank.sv
// tb/tb_mem_sram_bank.sv - scoreboard bench for mem_sram_bank against an array reference model
module tb_mem_sram_bank;

  localparam int LAT = 3;
  localparam int NW  = 1024;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, mem_req_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_strb_i;
  logic [5:0]  mem_atop_i;
  logic        mem_gnt_o, mem_rvalid_o, atop_err_o;
  logic [31:0] mem_rdata_o;

  always #5 clk_i = ~clk_i;

  mem_sram_bank #(
    .AddrWidth(32), .DataWidth(32), .NumWords(NW), .Latency(LAT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_strb_i(mem_strb_i), .mem_atop_i(mem_atop_i),
    .mem_we_i(mem_we_i), .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
    .atop_err_o(atop_err_o)
  );

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [NW];
  bit          known [NW];
  bit          exp_atop = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = '0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response and checks timing, data, hold and flag.
  initial begin
    exp_t e;
    bit   r;
    forever begin
      @(posedge clk_i);
      cyc++;
      r = rst_i;
      #1;
      if (r) begin
        cmp("rst_rvalid", {31'b0, mem_rvalid_o}, 32'd0);
        cmp("rst_rdata", mem_rdata_o, 32'd0);
        last_rdata = '0;
      end else if (mem_rvalid_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          cmp("rvalid_cycle", cyc, e.due);
          if (e.chk) cmp("rdata", mem_rdata_o, e.data);
        end
        last_rdata = mem_rdata_o;
      end else begin
        cmp("rdata_hold", mem_rdata_o, last_rdata);
        if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
          e = sb_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_rvalid actual=0 expected=1 (due cycle %0d)", e.due);
        end
      end
      cmp("atop_err", {31'b0, atop_err_o}, {31'b0, exp_atop});
    end
  end

  // One driven cycle; the model is updated only for requests that are actually granted.
  task automatic cycle(input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       input logic [5:0] atop, input bit stall, input bit rst,
                       output bit granted);
    logic [9:0] idx;
    bit         g;
    exp_t       e;
    @(negedge clk_i);
    rst_i = rst; stall_i = stall; mem_req_i = req; mem_we_i = we;
    mem_addr_i = addr; mem_wdata_i = data; mem_strb_i = strb; mem_atop_i = atop;
    if (rst) begin
      sb_q.delete();
      exp_atop = 1'b0;
    end
    #1;
    g = req && !stall && !rst;
    cmp("gnt", {31'b0, mem_gnt_o}, {31'b0, g});
    granted = g;
    if (g) begin
      idx = addr[11:2];
      e.data = model[idx];
      e.chk  = known[idx];
      e.due  = cyc + LAT;
      sb_q.push_back(e);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        if (strb == 4'hF) known[idx] = 1'b1;
      end
      if (atop != 6'h00) exp_atop = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    bit g;
    repeat (n) cycle(0, 0, '0, '0, '0, '0, 0, 0, g);
  endtask

  initial begin
    bit          g;
    int          j, k, tries;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [5:0]  at;
    bit          w, st;

    rst_i = 1; stall_i = 0; mem_req_i = 0; mem_we_i = 0;
    mem_addr_i = '0; mem_wdata_i = '0; mem_strb_i = '0; mem_atop_i = '0;
    for (int i = 0; i < NW; i++) known[i] = 1'b0;

    // Reset with a pending atomic write: nothing granted, flag stays low.
    repeat (3) cycle(1, 1, 32'h20, 32'hFFFF_FFFF, 4'hF, 6'h20, 0, 1, g);

    // Preload so every word has a modelled value.
    for (int i = 0; i < NW; i++) cycle(1, 1, i * 4, $urandom, 4'hF, 6'h00, 0, 0, g);
    idle(LAT + 1);

    // Write attempted during reset must not land.
    repeat (3) cycle(1, 1, 32'h20, 32'hCAFE_F00D, 4'hF, 6'h00, 0, 1, g);
    cycle(1, 0, 32'h20, '0, 4'h0, 6'h00, 0, 0, g);

    // Write then back-to-back read.
    cycle(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 6'h00, 0, 0, g);
    cycle(1, 0, 32'h10, '0, 4'h0, 6'h00, 0, 0, g);

    // Partial strobe merge, plus an all-zero strobe no-op write.
    cycle(1, 1, 32'h8, 32'h1122_3344, 4'hF, 6'h00, 0, 0, g);
    cycle(1, 1, 32'h8, 32'hAABB_CCDD, 4'b0101, 6'h00, 0, 0, g);
    cycle(1, 1, 32'h8, 32'h9999_9999, 4'b0000, 6'h00, 0, 0, g);
    cycle(1, 0, 32'h8, '0, 4'h0, 6'h00, 0, 0, g);
    idle(LAT + 1);

    // Eight streamed reads with stall on cycles 2 and 3.
    j = 0; k = 0;
    while (k < 8 && j < 16) begin
      cycle(1, 0, 32'h100 + k * 4, '0, 4'h0, 6'h00, (j == 2 || j == 3), 0, g);
      if (g) k++;
      j++;
    end
    idle(LAT + 1);

    // Wrapped address with atomic code, read back through the low alias.
    cycle(1, 1, 32'h1000_0004, 32'h5A5A_5A5A, 4'hF, 6'h20, 0, 0, g);
    cycle(1, 0, 32'h4, '0, 4'h0, 6'h00, 0, 0, g);
    idle(LAT + 2);

    // Reset with reads in flight; earlier write persists.
    cycle(1, 1, 32'h40, 32'h0BAD_CAFE, 4'hF, 6'h00, 0, 0, g);
    cycle(1, 0, 32'h40, '0, 4'h0, 6'h00, 0, 0, g);
    cycle(1, 0, 32'h44, '0, 4'h0, 6'h00, 0, 0, g);
    cycle(1, 0, 32'h48, '0, 4'h0, 6'h00, 0, 1, g);
    cycle(0, 0, '0, '0, 4'h0, 6'h00, 0, 1, g);
    cycle(1, 0, 32'h40, '0, 4'h0, 6'h00, 0, 0, g);
    idle(LAT + 1);

    // Randomised traffic with stalls, idles and occasional atomics.
    for (int n = 0; n < 400; n++) begin
      w  = $urandom_range(0, 1);
      a  = $urandom;
      d  = $urandom;
      s  = $urandom;
      at = ($urandom_range(0, 19) == 0) ? 6'h20 : 6'h00;
      tries = 0;
      do begin
        st = (tries < 8) && ($urandom_range(0, 3) == 0);
        cycle(1, w, a, d, s, at, st, 0, g);
        tries++;
      end while (!g && tries < 10);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    idle(LAT + 3);
    cmp("scoreboard_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
